divisor_sched: RTL and testbench

Round-robin scheduler that shares one `divisor_restoring` instance among `N_REQ` requesters. It captures one request at a time, sequences the divider's `start`/`done` handshake, and returns the quotient and remainder on a shared response channel tagged with the requester index. Divide-by-zero requests bypass the divider entirely. It sits between the client blocks and the divider; the divider's ports connect directly to the `div_*` ports.

---
 rtl/divisor_sched_pkg.sv | 15 +
 rtl/divisor_restoring.sv | 64 ++++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/divisor_sched.sv | 131 +++++++++++++
 tb/tb_divisor_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_sched_pkg.sv
// Shared types and default sizes for the round-robin divider scheduler.
package divisor_sched_pkg;

  localparam int W_DEF     = 7;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/divisor_restoring.sv
// Restoring divider, one quotient bit per cycle; done pulses with q/r valid.
module divisor_restoring #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W:0]    w_shift;
  logic [W-1:0]  w_diff;
  logic          w_fit;

  // Low bits of the subtraction are exact whenever the trial fits.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_fit   = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[W-1:0] - r_dvs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_quo  <= a;
        r_dvs  <= b;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_fit ? w_diff : w_shift[W-1:0];
        r_quo <= {r_quo[W-2:0], w_fit};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign q    = r_quo;
  assign r    = r_rem;
  assign done = r_done;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IW'(j);
        gnt[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divisor_sched.sv
// Shares one divider among N_REQ requesters: round-robin grant, start/done
// sequencing, tagged response; divide-by-zero answered without the divider.
module divisor_sched
  import divisor_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_q,
  output logic [W-1:0]             rsp_r,
  output logic                     rsp_dz,
  output logic                     div_start,
  output logic [W-1:0]             div_a,
  output logic [W-1:0]             div_b,
  input  logic [W-1:0]             div_q,
  input  logic [W-1:0]             div_r,
  input  logic                     div_done
);

  localparam int IW = $clog2(N_REQ);

  sched_state_t     r_state;
  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_req_ready;
  logic             r_rsp_valid;
  logic [IW-1:0]    r_rsp_id;
  logic [W-1:0]     r_rsp_q;
  logic [W-1:0]     r_rsp_r;
  logic             r_rsp_dz;
  logic             r_div_start;
  logic [W-1:0]     r_div_a;
  logic [W-1:0]     r_div_b;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_any;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_sel_a = req_a[int'(w_gnt_idx)*W +: W];
  assign w_sel_b = req_b[int'(w_gnt_idx)*W +: W];

  // IDLE spends one extra cycle with req_ready high so the accept pulse is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_dz    <= 1'b0;
      r_div_start <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|r_req_ready) begin
            r_req_ready <= '0;
            if (r_div_b != '0) begin
              r_state     <= ISSUE;
              r_div_start <= 1'b1;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_q     <= '1;
              r_rsp_r     <= r_div_a;
              r_rsp_dz    <= 1'b1;
            end
          end else if (w_any) begin
            r_req_ready <= w_gnt;
            r_div_a     <= w_sel_a;
            r_div_b     <= w_sel_b;
            r_rsp_id    <= w_gnt_idx;
            r_ptr       <= (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
          end
        end
        ISSUE: r_state <= ARM;
        // A level done left over from the previous operation is ignored here.
        ARM:   r_state <= WAIT;
        WAIT: begin
          if (div_done) begin
            r_rsp_q     <= div_q;
            r_rsp_r     <= div_r;
            r_rsp_dz    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_r     = r_rsp_r;
  assign rsp_dz    = r_rsp_dz;
  assign div_start = r_div_start;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;

endmodule

// File: tb/tb_divisor_sched.sv
// Directed bench for divisor_sched driving a real divisor_restoring.
module tb_divisor_sched;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_q;
  logic [W-1:0]     rsp_r;
  logic             rsp_dz;
  logic             div_start;
  logic [W-1:0]     div_a;
  logic [W-1:0]     div_b;
  logic [W-1:0]     div_q;
  logic [W-1:0]     div_r;
  logic             div_done;

  always #5 clk = ~clk;

  divisor_sched #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_dz    (rsp_dz),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_done  (div_done)
  );

  divisor_restoring #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (div_a),
    .b     (div_b),
    .q     (div_q),
    .r     (div_r),
    .done  (div_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int n_start  = 0;
  int t_acc    = 0;
  int t_start  = 0;
  int t_rsp    = 0;
  logic [N-1:0] keep;
  int glog[$];
  int rid[$];
  int rq[$];
  int rr[$];
  int rdz[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic clear_logs();
    glog.delete(); rid.delete(); rq.delete(); rr.delete(); rdz.delete();
    n_start = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check_eq({tag, "_req_ready"}, 32'(req_ready), 0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, "_rsp_id"},    32'(rsp_id),    0);
    check_eq({tag, "_rsp_q"},     32'(rsp_q),     0);
    check_eq({tag, "_rsp_r"},     32'(rsp_r),     0);
    check_eq({tag, "_rsp_dz"},    32'(rsp_dz),    0);
    check_eq({tag, "_div_start"}, 32'(div_start), 0);
    check_eq({tag, "_div_a"},     32'(div_a),     0);
    check_eq({tag, "_div_b"},     32'(div_b),     0);
  endtask

  // One cycle: sample at the falling edge, log grants/starts, drop accepted requests.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (|req_ready) begin
      check_eq("ready_onehot", 32'($onehot(req_ready)), 1);
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          glog.push_back(k);
          t_acc = cyc_n;
          if (!keep[k]) req_valid[k] = 1'b0;
        end
      end
    end
    if (div_start) begin
      n_start++;
      t_start = cyc_n;
    end
  endtask

  // Collect nrsp responses; the first one is back-pressured for bp cycles.
  task automatic run(input int nrsp, input int bp);
    int got;
    int seen;
    int budget;
    logic [31:0] cur;
    logic [31:0] snap;
    got = 0; seen = 0; budget = 0; snap = '0;
    rsp_ready = 1'b0;
    while (got < nrsp && budget < 3000) begin
      step();
      budget++;
      if (rsp_valid) begin
        cur = 32'({rsp_id, rsp_q, rsp_r, rsp_dz});
        if (seen == 0) begin
          snap  = cur;
          t_rsp = cyc_n;
        end else begin
          check_eq("bp_stable", cur, snap);
        end
        seen++;
        if (got == 0 && seen <= bp) begin
          check_eq("bp_no_ready", 32'(req_ready), 0);
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          rid.push_back(int'(rsp_id));
          rq.push_back(int'(rsp_q));
          rr.push_back(int'(rsp_r));
          rdz.push_back(int'(rsp_dz));
          got++;
          seen = 0;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
    check_eq("rsp_count", got, nrsp);
    req_valid = '0;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q4[4];
    int exp_r4[4];
    int seen_v;
    exp_q4 = '{49, 33, 24, 19};
    exp_r4 = '{1, 0, 3, 4};

    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; keep = '0;
    step(); step();
    check_reset_outputs("rst0");
    rst = 1'b1;
    step(); step();

    // All four requesters at once, ptr starts at 0.
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, 99, i + 2);
    req_valid = 4'hF;
    run(4, 0);
    check_eq("all_ngrant", glog.size(), 4);
    check_eq("all_nstart", n_start, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("all_gnt", glog[i], i);
      check_eq("all_id",  rid[i],  i);
      check_eq("all_q",   rq[i],   exp_q4[i]);
      check_eq("all_r",   rr[i],   exp_r4[i]);
      check_eq("all_dz",  rdz[i],  0);
    end

    // Single request from requester 1.
    clear_logs();
    set_req(1, 50, 7);
    req_valid = 4'b0010;
    run(1, 0);
    check_eq("one_ngrant", glog.size(), 1);
    check_eq("one_gnt", glog[0], 1);
    check_eq("one_nstart", n_start, 1);
    check_eq("one_start_lat", t_start - t_acc, 1);
    check_eq("one_id", rid[0], 1);
    check_eq("one_q", rq[0], 7);
    check_eq("one_r", rr[0], 1);
    check_eq("one_dz", rdz[0], 0);

    // Divide by zero from requester 2.
    clear_logs();
    set_req(2, 99, 0);
    req_valid = 4'b0100;
    run(1, 0);
    check_eq("dz_gnt", glog[0], 2);
    check_eq("dz_nstart", n_start, 0);
    check_eq("dz_lat", t_rsp - t_acc, 1);
    check_eq("dz_id", rid[0], 2);
    check_eq("dz_q", rq[0], 127);
    check_eq("dz_r", rr[0], 99);
    check_eq("dz_dz", rdz[0], 1);

    // Fairness between two always-valid requesters.
    clear_logs();
    set_req(0, 7, 2);
    set_req(2, 7, 2);
    keep = 4'b0101;
    req_valid = 4'b0101;
    run(6, 0);
    keep = '0;
    check_eq("fair_ngrant", glog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check_eq("fair_gnt", glog[k], (k % 2 == 0) ? 0 : 2);
      check_eq("fair_id",  rid[k],  (k % 2 == 0) ? 0 : 2);
      check_eq("fair_q",   rq[k],   3);
      check_eq("fair_r",   rr[k],   1);
    end

    // Backpressure on requester 3 while requester 0 waits.
    clear_logs();
    set_req(3, 120, 10);
    set_req(0, 7, 2);
    req_valid = 4'b1001;
    run(2, 5);
    check_eq("bp_ngrant", glog.size(), 2);
    check_eq("bp_gnt0", glog[0], 3);
    check_eq("bp_gnt1", glog[1], 0);
    check_eq("bp_id0", rid[0], 3);
    check_eq("bp_q0", rq[0], 12);
    check_eq("bp_r0", rr[0], 0);
    check_eq("bp_dz0", rdz[0], 0);
    check_eq("bp_id1", rid[1], 0);
    check_eq("bp_q1", rq[1], 3);
    check_eq("bp_r1", rr[1], 1);

    // Reset while waiting on the divider.
    clear_logs();
    set_req(3, 120, 10);
    req_valid = 4'b1000;
    for (int k = 0; k < 50 && n_start == 0; k++) step();
    check_eq("rw_started", n_start, 1);
    step(); step();
    rst = 1'b0;
    check_reset_outputs("rw_a");
    step();
    check_reset_outputs("rw_b");
    step();
    rst = 1'b1;
    seen_v = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (rsp_valid) seen_v++;
    end
    check_eq("rw_no_rsp", seen_v, 0);
    clear_logs();
    req_valid = 4'b1000;
    run(1, 0);
    check_eq("rw_gnt", glog[0], 3);
    check_eq("rw_id", rid[0], 3);
    check_eq("rw_q", rq[0], 12);
    check_eq("rw_r", rr[0], 0);
    check_eq("rw_dz", rdz[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
